// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the 8 shared uio pins: grant, optional turnaround gap, then a
// burst of write (drive) or read (sample) beats until last / beat limit / request drop.
module uio_bus_arbiter #(
  parameter int NREQ      = 4,
  parameter int TURN_CYC  = 1,
  parameter int MAX_BEATS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_dir,
  input  logic [8*NREQ-1:0]         req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           gnt,
  output logic                      busy,
  output logic                      beat,
  output logic [7:0]                rd_data,
  output logic                      rd_valid,
  output logic [$clog2(NREQ)-1:0]   rd_id,
  input  logic [7:0]                uio_in,
  output logic [7:0]                uio_out,
  output logic [7:0]                uio_oe
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;

  typedef enum logic [1:0] {IDLE, TURN, XFER} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   owner, rr_ptr, win, owner_inc;
  logic            dir;
  logic [CW-1:0]   beat_cnt;
  logic [1:0]      turn_cnt;
  logic            found, grant, burst_end, cnt_hit, turn_done;

  // First requester at or after the rr pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[(int'(rr_ptr) + i) % NREQ]) begin
        found = 1'b1;
        win   = IW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end

  assign owner_inc = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign cnt_hit   = (MAX_BEATS != 0) && (beat_cnt == CW'(MAX_BEATS - 1));
  assign turn_done = (turn_cnt == 2'(TURN_CYC - 1));
  assign busy      = (state != IDLE);
  assign gnt       = busy ? (NREQ'(1) << owner) : '0;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    burst_end = 1'b0;
    beat      = 1'b0;
    uio_oe    = 8'h00;
    uio_out   = 8'h00;
    case (state)
      IDLE: begin
        if (ena && found) begin
          grant     = 1'b1;
          state_nxt = (TURN_CYC > 0) ? TURN : XFER;
        end
      end
      TURN: begin
        if (!req[owner]) begin
          burst_end = 1'b1;
          state_nxt = IDLE;
        end else if (turn_done) begin
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (dir) begin
          uio_oe  = 8'hFF;
          uio_out = req_data[8*int'(owner) +: 8];
        end
        if (!req[owner]) begin
          burst_end = 1'b1;
        end else begin
          beat = 1'b1;
          if (req_last[owner] || cnt_hit) burst_end = 1'b1;
        end
        if (burst_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      dir      <= 1'b0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      turn_cnt <= '0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      rd_id    <= '0;
    end else begin
      state    <= state_nxt;
      rd_valid <= beat && !dir;
      if (state == TURN) turn_cnt <= turn_cnt + 1'b1;
      if (beat) beat_cnt <= beat_cnt + 1'b1;
      // Direction is frozen here; later req_dir changes do not affect the burst.
      if (grant) begin
        owner    <= win;
        dir      <= req_dir[win];
        beat_cnt <= '0;
        turn_cnt <= '0;
      end
      if (beat && !dir) begin
        rd_data <= uio_in;
        rd_id   <= owner;
      end
      if (burst_end) rr_ptr <= owner_inc;
    end
  end

endmodule
